object_plotter: RTL and testbench
=================================

// Module: object_plotter
// PURPOSE
//  Parametrised object draw/erase engine that drives the VGA adapter pixel port (VGA_X/VGA_Y/VGA_COLOR/plot).
//  On a start request it scans an OBJ_W x OBJ_H box anchored at (x_in,y_in), one pixel per clock.
//  Drawing is either a solid rectangle or an inscribed disc (Connect4 token).
//  Adds erase mode, screen-edge clipping, busy/done handshake and hold-safe start over the fixed 4x4 object drawer.
// PARAMETERS
//  X_W      8    x coordinate width
//  Y_W      7    y coordinate width
//  C_W      3    colour width
//  OBJ_W    4    object width in pixels (>=1)
//  OBJ_H    4    object height in pixels (>=1)
//  X_RES    160  visible columns; pixels with x >= X_RES are clipped
//  Y_RES    120  visible rows; pixels with y >= Y_RES are clipped
//  BG_COLOR 0    colour written in erase mode
//  SHAPE    0    0 = rectangle; 1 = disc (requires OBJ_W == OBJ_H)
// PORTS
//  CLOCK_50   in   1    system clock; all logic on the rising edge
//  resetn     in   1    synchronous, active-low reset
//  start      in   1    level request (KEY-derived, already active-high)
//  erase      in   1    sampled with start: 1 = paint BG_COLOR instead of colour_in
//  x_in       in   X_W  anchor x (top-left corner), sampled at acceptance
//  y_in       in   Y_W  anchor y, sampled at acceptance
//  colour_in  in   C_W  draw colour, sampled at acceptance
//  busy       out  1    high in DRAW and DONE
//  done       out  1    one-cycle pulse after the last pixel
//  VGA_X      out  X_W  registered pixel x
//  VGA_Y      out  Y_W  registered pixel y
//  VGA_COLOR  out  C_W  registered pixel colour
//  plot       out  1    registered write strobe
// BEHAVIOUR
//  - Reset (resetn=0 at an edge): state IDLE; counters 0; busy, done, plot, VGA_X, VGA_Y, VGA_COLOR all 0.
//    Reset wins over every other input. Reset mid-draw aborts the scan; no done pulse is produced.
//  - FSM states:
//    IDLE: start=1 -> latch x_in, y_in, and (erase ? BG_COLOR : colour_in); clear cx, cy; go to DRAW.
//    DRAW: one pixel per cycle in raster order; cx runs 0..OBJ_W-1 inner, cy runs 0..OBJ_H-1 outer.
//      Leaves for DONE after pixel (OBJ_W-1, OBJ_H-1).
//    DONE: one cycle; done=1, plot=0; then go to HOLD.
//    HOLD: wait for start=0, then go to IDLE. A held key never redraws.
//  - Timing: acceptance edge is T. Pixel k (k = cy*OBJ_W + cx) appears on outputs during cycle T+1+k.
//    Scan is exactly OBJ_W*OBJ_H DRAW cycles, regardless of clipping or masking.
//  - Pixel address: x0+cx is formed at X_W+1 bits and y0+cy at Y_W+1 bits.
//    VGA_X and VGA_Y carry the low X_W and Y_W bits of those sums.
//  - plot=1 only when x0+cx < X_RES, y0+cy < Y_RES, and the mask passes.
//    Otherwise plot=0 and the cycle is still consumed.
//  - Disc mask (SHAPE=1, D=OBJ_W): pass iff (2cx-D+1)^2 + (2cy-D+1)^2 <= D^2, computed signed.
//    With D=4 the four corners fail, so 12 of 16 pixels pass.
//  - start, erase, x_in, y_in and colour_in are ignored outside IDLE; the latched values stay stable for the whole scan.
//  - Outside DRAW: plot=0. VGA_X, VGA_Y and VGA_COLOR hold their last values.
// STRUCTURE
//  - object_pkg: FSM state encoding (IDLE, DRAW, DONE, HOLD) and colour constants (BLACK, RED, YELLOW, BLUE).
//  - One sub-module, obj_pixel_mask: combinational clip and disc test.
//    Inputs: cx, cy, x0, y0. Output: pass.
//  - Top level holds the FSM, counters, anchor/colour latches and output registers.
// TESTING
//  1 Reset: resetn=0 for 2 cycles with start=1 -> all outputs 0, no plot. After release, a draw begins only from IDLE.
//  2 Rect draw: x=72, y=72, colour=3'b100, start held -> 16 plot cycles, (72,72)..(75,72), ..., (75,75).
//    Then done=1 at T+17 and busy low at T+18.
//  3 Erase: same anchor with erase=1, colour_in=3'b111 -> 16 pixels with VGA_COLOR=BG_COLOR (0).
//  4 Clipping: x=158, y=118 -> still 16 DRAW cycles.
//    Only (158,118), (159,118), (158,119), (159,119) have plot=1.
//  5 Hold/re-arm: start high for 40 cycles -> exactly one scan and one done pulse.
//    Drop start, raise it again -> a second scan.
//  6 SHAPE=1, x=10, y=10: corners (10,10), (13,10), (10,13), (13,13) have plot=0; the other 12 have plot=1.
//    Then reset asserted at pixel 5 of a new scan -> plot=0 next cycle, no done.

Source files
------------

// File: rtl/object_plotter_pkg.sv
// Shared types for the object plotter: FSM encoding and the board colour palette.
package object_plotter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDraw,
        StDone,
        StHold
    } state_e;

    localparam logic [2:0] BLACK  = 3'b000;
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b110;
    localparam logic [2:0] BLUE   = 3'b001;

endpackage

// File: rtl/obj_pixel_mask.sv
// Combinational per-pixel gate: screen-edge clip plus optional inscribed-disc mask.
module obj_pixel_mask #(
    parameter int unsigned X_W   = 8,
    parameter int unsigned Y_W   = 7,
    parameter int unsigned CX_W  = 2,
    parameter int unsigned CY_W  = 2,
    parameter int unsigned OBJ_W = 4,
    parameter int unsigned X_RES = 160,
    parameter int unsigned Y_RES = 120,
    parameter int unsigned SHAPE = 0
) (
    input  logic [CX_W-1:0] cx_i,
    input  logic [CY_W-1:0] cy_i,
    input  logic [X_W-1:0]  x0_i,
    input  logic [Y_W-1:0]  y0_i,
    output logic            pass_o
);

    logic [X_W:0] x_sum;
    logic [Y_W:0] y_sum;
    logic         x_ok;
    logic         y_ok;
    logic         in_disc;
    int           dx;
    int           dy;

    always_comb begin
        // One extra bit so anchors near the edge cannot wrap back on screen.
        x_sum   = {1'b0, x0_i} + (X_W+1)'(cx_i);
        y_sum   = {1'b0, y0_i} + (Y_W+1)'(cy_i);
        x_ok    = 32'(x_sum) < X_RES;
        y_ok    = 32'(y_sum) < Y_RES;
        // Doubled offsets from the box centre keep the test in integers.
        dx      = 2 * int'(cx_i) - int'(OBJ_W) + 1;
        dy      = 2 * int'(cy_i) - int'(OBJ_W) + 1;
        in_disc = (dx * dx + dy * dy) <= int'(OBJ_W * OBJ_W);
        pass_o  = x_ok && y_ok && ((SHAPE == 0) || in_disc);
    end

endmodule

// File: rtl/object_plotter.sv
// Object draw/erase engine: scans an OBJ_W x OBJ_H box one pixel per clock into the VGA pixel port.
module object_plotter
    import object_plotter_pkg::*;
#(
    parameter int unsigned X_W      = 8,
    parameter int unsigned Y_W      = 7,
    parameter int unsigned C_W      = 3,
    parameter int unsigned OBJ_W    = 4,
    parameter int unsigned OBJ_H    = 4,
    parameter int unsigned X_RES    = 160,
    parameter int unsigned Y_RES    = 120,
    parameter int unsigned BG_COLOR = 0,
    parameter int unsigned SHAPE    = 0
) (
    input  logic           CLOCK_50,
    input  logic           resetn,
    input  logic           start,
    input  logic           erase,
    input  logic [X_W-1:0] x_in,
    input  logic [Y_W-1:0] y_in,
    input  logic [C_W-1:0] colour_in,
    output logic           busy,
    output logic           done,
    output logic [X_W-1:0] VGA_X,
    output logic [Y_W-1:0] VGA_Y,
    output logic [C_W-1:0] VGA_COLOR,
    output logic           plot
);

    localparam int unsigned CX_W = (OBJ_W > 1) ? $clog2(OBJ_W) : 1;
    localparam int unsigned CY_W = (OBJ_H > 1) ? $clog2(OBJ_H) : 1;
    localparam logic [CX_W-1:0] CxLast = CX_W'(OBJ_W - 1);
    localparam logic [CY_W-1:0] CyLast = CY_W'(OBJ_H - 1);

    state_e          state_q, state_d;
    logic [CX_W-1:0] cx_q, cx_d;
    logic [CY_W-1:0] cy_q, cy_d;
    logic [X_W-1:0]  x0_q, x0_d;
    logic [Y_W-1:0]  y0_q, y0_d;
    logic [C_W-1:0]  col_q, col_d;
    logic [X_W-1:0]  vga_x_q, vga_x_d;
    logic [Y_W-1:0]  vga_y_q, vga_y_d;
    logic [C_W-1:0]  vga_col_q, vga_col_d;
    logic            plot_q, plot_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            pix_pass;

    obj_pixel_mask #(
        .X_W   (X_W),
        .Y_W   (Y_W),
        .CX_W  (CX_W),
        .CY_W  (CY_W),
        .OBJ_W (OBJ_W),
        .X_RES (X_RES),
        .Y_RES (Y_RES),
        .SHAPE (SHAPE)
    ) u_mask (
        .cx_i   (cx_q),
        .cy_i   (cy_q),
        .x0_i   (x0_q),
        .y0_i   (y0_q),
        .pass_o (pix_pass)
    );

    always_comb begin
        state_d   = state_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        x0_d      = x0_q;
        y0_d      = y0_q;
        col_d     = col_q;
        vga_x_d   = vga_x_q;
        vga_y_d   = vga_y_q;
        vga_col_d = vga_col_q;
        plot_d    = 1'b0;
        done_d    = 1'b0;
        busy_d    = (state_q == StDraw) || (state_q == StDone);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    x0_d    = x_in;
                    y0_d    = y_in;
                    col_d   = erase ? C_W'(BG_COLOR) : colour_in;
                    cx_d    = '0;
                    cy_d    = '0;
                    state_d = StDraw;
                end
            end
            StDraw: begin
                vga_x_d   = x0_q + X_W'(cx_q);
                vga_y_d   = y0_q + Y_W'(cy_q);
                vga_col_d = col_q;
                plot_d    = pix_pass;
                if (cx_q == CxLast) begin
                    cx_d = '0;
                    if (cy_q == CyLast) begin
                        cy_d    = '0;
                        state_d = StDone;
                    end else begin
                        cy_d = cy_q + CY_W'(1);
                    end
                end else begin
                    cx_d = cx_q + CX_W'(1);
                end
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = StHold;
            end
            StHold: begin
                // A held key must be released before another draw is accepted.
                if (!start) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q   <= StIdle;
            cx_q      <= '0;
            cy_q      <= '0;
            x0_q      <= '0;
            y0_q      <= '0;
            col_q     <= '0;
            vga_x_q   <= '0;
            vga_y_q   <= '0;
            vga_col_q <= C_W'(BLACK);
            plot_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            x0_q      <= x0_d;
            y0_q      <= y0_d;
            col_q     <= col_d;
            vga_x_q   <= vga_x_d;
            vga_y_q   <= vga_y_d;
            vga_col_q <= vga_col_d;
            plot_q    <= plot_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign VGA_X     = vga_x_q;
    assign VGA_Y     = vga_y_q;
    assign VGA_COLOR = vga_col_q;
    assign plot      = plot_q;

endmodule

// File: tb/tb_object_plotter.sv
// Directed bench for object_plotter: a rectangle instance and a disc instance share one stimulus.
module tb_object_plotter;

    logic       clk;
    logic       resetn;
    logic       start;
    logic       erase;
    logic [7:0] x_in;
    logic [6:0] y_in;
    logic [2:0] colour_in;

    logic       r_busy, r_done, r_plot;
    logic [7:0] r_x;
    logic [6:0] r_y;
    logic [2:0] r_col;
    logic       d_busy, d_done, d_plot;
    logic [7:0] d_x;
    logic [6:0] d_y;
    logic [2:0] d_col;

    int tests  = 0;
    int failed = 0;

    typedef struct packed {
        logic [7:0]  x;
        logic [6:0]  y;
        logic [2:0]  colour;
        logic        erase;
        logic        disc;
        logic [2:0]  exp_col;
        logic [15:0] exp_mask;
    } vec_t;

    vec_t vecs[4];

    object_plotter #(.SHAPE(0)) dut_rect (
        .CLOCK_50  (clk),
        .resetn    (resetn),
        .start     (start),
        .erase     (erase),
        .x_in      (x_in),
        .y_in      (y_in),
        .colour_in (colour_in),
        .busy      (r_busy),
        .done      (r_done),
        .VGA_X     (r_x),
        .VGA_Y     (r_y),
        .VGA_COLOR (r_col),
        .plot      (r_plot)
    );

    object_plotter #(.SHAPE(1)) dut_disc (
        .CLOCK_50  (clk),
        .resetn    (resetn),
        .start     (start),
        .erase     (erase),
        .x_in      (x_in),
        .y_in      (y_in),
        .colour_in (colour_in),
        .busy      (d_busy),
        .done      (d_done),
        .VGA_X     (d_x),
        .VGA_Y     (d_y),
        .VGA_COLOR (d_col),
        .plot      (d_plot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] pix_word(input logic disc);
        // {x, y, colour, plot, busy}
        if (disc) return 32'({d_x, d_y, d_col, d_plot, d_busy});
        return 32'({r_x, r_y, r_col, r_plot, r_busy});
    endfunction

    function automatic logic [31:0] ctl_word(input logic disc);
        // {done, busy, plot}
        if (disc) return 32'({d_done, d_busy, d_plot});
        return 32'({r_done, r_busy, r_plot});
    endfunction

    task automatic run_scan(input vec_t v, input int idx);
        logic [7:0]  ex;
        logic [6:0]  ey;
        logic [31:0] exp_w;
        x_in      = v.x;
        y_in      = v.y;
        colour_in = v.colour;
        erase     = v.erase;
        start     = 1'b1;
        step();
        // Inputs must be ignored once the scan is accepted.
        x_in      = ~v.x;
        y_in      = ~v.y;
        colour_in = ~v.colour;
        erase     = ~v.erase;
        for (int k = 0; k < 16; k++) begin
            step();
            ex    = v.x + 8'(k % 4);
            ey    = v.y + 7'(k / 4);
            exp_w = 32'({ex, ey, v.exp_col, v.exp_mask[k], 1'b1});
            check($sformatf("vec%0d_pix%0d", idx, k), pix_word(v.disc), exp_w);
        end
        step();
        check($sformatf("vec%0d_done", idx), ctl_word(v.disc), 32'b110);
        step();
        check($sformatf("vec%0d_idle", idx), ctl_word(v.disc), 32'b000);
        start = 1'b0;
        step();
        step();
    endtask

    task automatic count_cycles(input int n, output int plots, output int dones);
        plots = 0;
        dones = 0;
        for (int i = 0; i < n; i++) begin
            step();
            plots += int'(r_plot) + int'(d_plot);
            dones += int'(r_done) + int'(d_done);
        end
    endtask

    initial begin
        int plots, dones;

        vecs[0] = '{8'd72,  7'd72,  3'b100, 1'b0, 1'b0, 3'b100, 16'hFFFF};
        vecs[1] = '{8'd72,  7'd72,  3'b111, 1'b1, 1'b0, 3'b000, 16'hFFFF};
        vecs[2] = '{8'd158, 7'd118, 3'b010, 1'b0, 1'b0, 3'b010, 16'h0033};
        vecs[3] = '{8'd10,  7'd10,  3'b110, 1'b0, 1'b1, 3'b110, 16'h6FF6};

        resetn    = 1'b0;
        start     = 1'b1;
        erase     = 1'b0;
        x_in      = 8'd33;
        y_in      = 7'd44;
        colour_in = 3'b101;

        // Reset with start held: everything cleared.
        step();
        step();
        check("reset_rect", 32'({r_x, r_y, r_col, r_plot, r_busy, r_done}), 32'd0);
        check("reset_disc", 32'({d_x, d_y, d_col, d_plot, d_busy, d_done}), 32'd0);
        start  = 1'b0;
        resetn = 1'b1;
        step();
        step();
        check("post_reset_idle", 32'({r_busy, r_plot, d_busy, d_plot}), 32'd0);

        for (int i = 0; i < 4; i++) begin
            run_scan(vecs[i], i);
        end

        // Held start gives exactly one scan per instance; release and re-press gives another.
        x_in      = 8'd20;
        y_in      = 7'd30;
        colour_in = 3'b001;
        erase     = 1'b0;
        start     = 1'b1;
        count_cycles(40, plots, dones);
        check("hold_plots", 32'(plots), 32'd28);
        check("hold_dones", 32'(dones), 32'd2);
        start = 1'b0;
        step();
        step();
        start = 1'b1;
        count_cycles(30, plots, dones);
        check("rearm_plots", 32'(plots), 32'd28);
        check("rearm_dones", 32'(dones), 32'd2);
        start = 1'b0;
        step();
        step();

        // Reset while pixel 5 of a disc scan is on the outputs.
        x_in      = 8'd10;
        y_in      = 7'd10;
        colour_in = 3'b100;
        start     = 1'b1;
        step();
        for (int k = 0; k < 6; k++) step();
        check("midscan_pix5", pix_word(1'b1), 32'({8'd11, 7'd11, 3'b100, 1'b1, 1'b1}));
        resetn = 1'b0;
        step();
        check("abort_rect", 32'({r_plot, r_busy, r_done, r_x}), 32'd0);
        check("abort_disc", 32'({d_plot, d_busy, d_done, d_x}), 32'd0);
        start = 1'b0;
        step();
        resetn = 1'b1;
        count_cycles(25, plots, dones);
        check("abort_no_plot", 32'(plots), 32'd0);
        check("abort_no_done", 32'(dones), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
